// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock / reset sequencer.
package pll_seq_pkg;

  // Sequencer states; HOLD is the reset state.
  typedef enum logic [1:0] {
    StHold     = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } pll_state_e;

  localparam int unsigned DefSyncStages    = 2;
  localparam int unsigned DefPllrstCycles  = 16;
  localparam int unsigned DefStableCycles  = 1024;
  localparam int unsigned DefTimeoutCycles = 65536;
  localparam int unsigned DefLossCntW      = 8;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// Status/reset bundle between the PLL wrapper side and the lock sequencer.
interface pll_lock_reset_seq_if
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOSS_CNT_W = DefLossCntW
) ();

  logic                  locked_async;
  logic                  pll_rst;
  logic                  sys_rstn;
  logic                  ready;
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss_count;

  // Environment side: supplies PLL lock, consumes resets and status.
  modport master (
    output locked_async,
    input  pll_rst,
    input  sys_rstn,
    input  ready,
    input  lock_lost,
    input  loss_count
  );

  // Sequencer side.
  modport slave (
    input  locked_async,
    output pll_rst,
    output sys_rstn,
    output ready,
    output lock_lost,
    output loss_count
  );

endinterface

// File: rtl/lock_sync.sv
// Multi-flop synchroniser for a slow asynchronous status flag.
module lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  // Shift the flag one stage further along the chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Chain flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier: releases sys_rstn after a stable lock, re-resets the PLL on loss.
// Optional macro PLL_LOCK_TIMEOUT_EN: retry the PLL reset if lock never arrives.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DefSyncStages,
  parameter int unsigned PLLRST_CYCLES  = DefPllrstCycles,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned LOSS_CNT_W     = DefLossCntW
) (
  input logic                 clk,
  input logic                 rstn,
  pll_lock_reset_seq_if.slave bus
);

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned MaxCycles =
    max2(max2(PLLRST_CYCLES, STABLE_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int unsigned MaxCycles = max2(PLLRST_CYCLES, STABLE_CYCLES);
`endif
  localparam int unsigned CntW = cnt_width(MaxCycles);

  localparam logic [CntW-1:0] PllrstLast  = CntW'(PLLRST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

  // Elaboration-time guard on parameter minimums.
  if (SYNC_STAGES < 2 || PLLRST_CYCLES < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("pll_lock_reset_seq: parameter below its minimum");
  end

  logic locked_s;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (bus.locked_async),
    .q_o (locked_s)
  );

  pll_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rstn_q, sys_rstn_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Next state, shared counter and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    lock_lost_d = 1'b0;
    loss_d      = loss_q;

    unique case (state_q)
      StHold: begin
        if (cnt_q == PllrstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          state_d = StHold;
        end
`else
        // Waiting is unbounded, so the counter has nothing to measure here.
        cnt_d = '0;
`endif
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d     = StHold;
          lock_lost_d = 1'b1;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      default: begin
        state_d = StHold;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs follow the state being entered so they switch on the same edge.
    pll_rst_d  = (state_d == StHold);
    sys_rstn_d = (state_d == StRun);
    ready_d    = (state_d == StRun);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rstn_q  <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rstn_q  <= sys_rstn_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      loss_q      <= loss_d;
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.sys_rstn   = sys_rstn_q;
  assign bus.ready      = ready_q;
  assign bus.lock_lost  = lock_lost_q;
  assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus random lock traffic vs. a model.
module tb_pll_lock_reset_seq;

  localparam int unsigned Sync = 2;
  localparam int unsigned Pr   = 4;
  localparam int unsigned St   = 8;
  localparam int unsigned To   = 20;
  localparam int unsigned Lw   = 2;
  localparam int unsigned LossMax = (1 << Lw) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pll_lock_reset_seq_if #(.LOSS_CNT_W(Lw)) bus ();

  pll_lock_reset_seq #(
    .SYNC_STAGES   (Sync),
    .PLLRST_CYCLES (Pr),
    .STABLE_CYCLES (St),
    .TIMEOUT_CYCLES(To),
    .LOSS_CNT_W    (Lw)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired, got none, expected event (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Lock history delay line, remaining PLL-reset cycles, consecutive-lock streak,
  // consecutive lock-less waiting cycles, and the running flag.
  bit m_sh[Sync];
  int m_hold, m_streak, m_wait, m_loss;
  bit m_run, m_lost;

  task automatic m_reset();
    for (int i = 0; i < Sync; i++) m_sh[i] = 1'b0;
    m_hold = Pr; m_streak = 0; m_wait = 0; m_loss = 0; m_run = 1'b0; m_lost = 1'b0;
  endtask

  task automatic m_step();
    bit ls;
    ls = m_sh[Sync-1];
    for (int i = Sync - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = bus.locked_async;
    m_lost = 1'b0;
    if (m_run) begin
      if (!ls) begin
        m_run = 1'b0; m_hold = Pr; m_lost = 1'b1; m_streak = 0; m_wait = 0;
        if (m_loss < LossMax) m_loss++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (ls) begin
      // First locked cycle arms the check, then St more are required.
      m_streak++; m_wait = 0;
      if (m_streak == St + 1) begin m_run = 1'b1; m_streak = 0; end
    end else if (m_streak > 0) begin
      m_streak = 0; m_wait = 0;
    end else begin
      m_wait++;
`ifdef PLL_LOCK_TIMEOUT_EN
      if (m_wait == To) begin m_hold = Pr; m_wait = 0; end
`endif
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("pll_rst",    bus.pll_rst,    (m_hold > 0) ? 1 : 0);
      chk("sys_rstn",   bus.sys_rstn,   m_run);
      chk("ready",      bus.ready,      m_run);
      chk("lock_lost",  bus.lock_lost,  m_lost);
      chk("loss_count", bus.loss_count, m_loss);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_lock(input bit v);
    @(posedge clk);
    #2;
    bus.locked_async = v;
  endtask

  task automatic wait_sysrstn(input bit v, input string name, output int e);
    e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.sys_rstn === v) begin e = edge_n; break; end
    end
    if (e < 0) bound_fail(name);
  endtask

  task automatic wait_pll(input bit v, input string name, output int e);
    e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pll_rst === v) begin e = edge_n; break; end
    end
    if (e < 0) bound_fail(name);
  endtask

  // Release rstn at a falling edge and check pll_rst stays high for Pr edges.
  task automatic release_and_hold();
    int n;
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (!bus.pll_rst) break;
    end
    chk("pll_rst_hold_edges", n, Pr);
  endtask

  // Asynchronous reset between clock edges, with immediate output checks.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_pll_rst",    bus.pll_rst,    1);
    chk("rst_sys_rstn",   bus.sys_rstn,   0);
    chk("rst_ready",      bus.ready,      0);
    chk("rst_lock_lost",  bus.lock_lost,  0);
    chk("rst_loss_count", bus.loss_count, 0);
    repeat (2) @(posedge clk);
    release_and_hold();
  endtask

  int s, e, e2;
  int sat_exp[5];

  initial begin
    bus.locked_async = 1'b0;
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

    // Power-up.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_pll_rst",   bus.pll_rst,    1);
    chk("por_sys_rstn",  bus.sys_rstn,   0);
    chk("por_ready",     bus.ready,      0);
    chk("por_lock_lost", bus.lock_lost,  0);
    chk("por_loss",      bus.loss_count, 0);
    release_and_hold();
    repeat (5) @(posedge clk);
    drive_lock(1'b1);
    s = edge_n + 1;
    wait_sysrstn(1'b1, "release", e);
    // Counting the sampling edge as edge 1, release lands on edge Sync+1+St.
    chk("release_latency", e - s, Sync + St);
    chk("release_ready", bus.ready, 1);

    // Loss of lock in RUN.
    repeat (5) @(posedge clk);
    drive_lock(1'b0);
    s = edge_n + 1;
    wait_sysrstn(1'b0, "loss", e);
    chk("loss_latency", e - s, Sync);
    chk("loss_pulse", bus.lock_lost, 1);
    chk("loss_count_1", bus.loss_count, 1);
    chk("loss_pll_rst", bus.pll_rst, 1);
    @(negedge clk);
    chk("loss_pulse_end", bus.lock_lost, 0);

    // Glitch while qualifying: the stable count restarts.
    wait_pll(1'b0, "glitch_hold", e);
    drive_lock(1'b1);
    repeat (4) @(posedge clk);
    drive_lock(1'b0);
    repeat (2) @(posedge clk);
    drive_lock(1'b1);
    s = edge_n + 1;
    wait_sysrstn(1'b1, "glitch_release", e);
    chk("glitch_release_latency", e - s, Sync + St);
    chk("glitch_loss_count", bus.loss_count, 1);

    // Async reset mid-RUN.
    async_reset();
    chk("post_rst_sys_rstn", bus.sys_rstn, 0);

    // Loss counter saturation.
    for (int i = 0; i < 5; i++) begin
      wait_pll(1'b0, "sat_hold", e);
      drive_lock(1'b1);
      wait_sysrstn(1'b1, "sat_up", e);
      drive_lock(1'b0);
      wait_sysrstn(1'b0, "sat_down", e);
      chk($sformatf("loss_count_sat%0d", i), bus.loss_count, sat_exp[i]);
    end

    // Random lock traffic; the model does the checking.
    async_reset();
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
      drive_lock(1'($urandom_range(0, 1)));
      repeat (len - 1) @(posedge clk);
    end

    // Lock never arrives.
    bus.locked_async = 1'b0;
    async_reset();
`ifdef PLL_LOCK_TIMEOUT_EN
    wait_pll(1'b1, "timeout_first", e);
    wait_pll(1'b0, "timeout_low", e2);
    wait_pll(1'b1, "timeout_second", e2);
    chk("timeout_period", e2 - e, Pr + To);
`else
    begin
      int highs;
      highs = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.pll_rst) highs++;
      end
      chk("no_timeout_pll_rst", highs, 0);
    end
`endif
    chk("timeout_loss_count", bus.loss_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
- Consumer end of the ECP5 PLL clock wrapper: takes the PLL `locked` flag and produces a clean, qualified system reset plus a PLL reset request.
- Runs on the free-running board reference clock (25 MHz `clkin`), not on a PLL output, so it keeps running while the PLL is unlocked.
- `sys_rstn` is released only after lock has been continuously stable for a programmable time.
- On loss of lock it re-asserts the system reset, pulses the PLL reset and counts loss events.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising `locked_async` into `clk`; minimum 2.
- PLLRST_CYCLES, 16, cycles `pll_rst` is held high per PLL reset request; minimum 1.
- STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release; minimum 1.
- TIMEOUT_CYCLES, 65536, cycles in WAIT_LOCK before PLL reset is retried (only with LOCK_TIMEOUT_EN).
- LOSS_CNT_W, 8, width of the loss-of-lock event counter.

Ports:
- clk  in  1  free-running reference clock.
- rstn  in  1  asynchronous, active-low reset.
- locked_async  in  1  PLL LOCK output, asynchronous to `clk`.
- pll_rst  out  1  active-high request to the PLL RST pin.
- sys_rstn  out  1  active-low system reset, registered in `clk`.
- ready  out  1  high while state is RUN.
- lock_lost  out  1  one-cycle pulse on each loss of lock seen in RUN.
- loss_count  out  LOSS_CNT_W  saturating count of lock_lost events.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rstn` is asynchronous and active-low.
- While `rstn` is low, all outputs are forced immediately (asynchronously):
  - state=HOLD, cnt=0, synchroniser flops=0.
  - pll_rst=1, sys_rstn=0, ready=0, lock_lost=0, loss_count=0.
- `rstn` overrides every other event.
- `locked_s` is the output of the SYNC_STAGES flop chain; the FSM uses only `locked_s`.
- `cnt` is a shared state counter, width clog2 of the largest cycle parameter. It clears on every state change.
- All outputs are registered; `ready` = (state==RUN); `sys_rstn` changes on the same edge that the state enters or leaves RUN.
- HOLD:
  - pll_rst=1.
  - When cnt==PLLRST_CYCLES-1, go to WAIT_LOCK and drive pll_rst=0 on that edge.
  - `locked_s` is ignored in HOLD.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Otherwise stay (timeout behaviour under Optional Feature).
- STABLE:
  - If locked_s=0 (glitch), return to WAIT_LOCK; no lock_lost pulse, no count.
  - If locked_s=1 and cnt==STABLE_CYCLES-1, go to RUN and set sys_rstn=1.
  - Otherwise cnt increments.
- RUN:
  - If locked_s=0, on the next edge: state=HOLD, sys_rstn=0, pll_rst=1, lock_lost=1 for exactly one cycle.
  - On the same edge, loss_count increments, saturating at all-ones.
- Latency:
  - Release: sys_rstn rises SYNC_STAGES+1+STABLE_CYCLES edges after the first edge that samples locked_async=1, given lock stays high (defaults: 1027).
  - Loss: sys_rstn falls SYNC_STAGES+1 edges after the first edge sampling locked_async=0.
- loss_count is cleared only by `rstn`.
- A locked_async pulse shorter than one `clk` period may be missed; this is acceptable.

Optional Feature:
- Macro: PLL_LOCK_TIMEOUT_EN.
- Defined: in WAIT_LOCK, when cnt==TIMEOUT_CYCLES-1 with locked_s=0, go to HOLD (pll_rst=1 again). This does not pulse lock_lost and does not change loss_count.
- Undefined: WAIT_LOCK waits indefinitely; the TIMEOUT_CYCLES parameter is unused and the counter is sized without it.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum HOLD/WAIT_LOCK/STABLE/RUN (2-bit encoding).
  - default constants for the four cycle parameters.
  - clog2 helper for counter sizing.
- One natural sub-module, `lock_sync`:
  - SYNC_STAGES-deep flop chain with asynchronous clear on `rstn`.
  - Reusable for other asynchronous status flags.

Test Plan (STABLE_CYCLES=8, PLLRST_CYCLES=4, SYNC_STAGES=2 unless noted):
- Power-up: rstn low then high; locked_async high from cycle 10 → pll_rst high for exactly 4 cycles after reset release; sys_rstn rises exactly 11 edges after the first edge sampling lock high; ready rises with it.
- Glitch during STABLE: lock drops for 3 cycles at STABLE cnt=5 → return to WAIT_LOCK; the full 8-cycle count restarts after lock returns; lock_lost stays 0; loss_count=0.
- Loss in RUN: drop locked_async → 3 edges later sys_rstn=0, ready=0, pll_rst=1 for 4 cycles, lock_lost high for 1 cycle, loss_count=1.
- Saturation: LOSS_CNT_W=2; 5 lock/loss cycles → loss_count sequence 1,2,3,3,3.
- Timeout (macro defined, TIMEOUT_CYCLES=20): lock never asserted → pll_rst re-asserts every 4+20 cycles; loss_count stays 0. With macro undefined: pll_rst stays 0 indefinitely after the first HOLD.
- Async reset mid-RUN: rstn low between clock edges → sys_rstn=0 and pll_rst=1 immediately; loss_count=0; sequence restarts from HOLD after release.
